// File: rtl/mps_sequencer.sv
// mps_sequencer: walks each instruction FETCH/DECODE/EXECUTE/[MEMORY]/WRITEBACK, one stage per cycle.
// Latency: 4 cycles for non-memory instructions, 5+N for memory ones (N = not-ready MEMORY cycles).
// Backpressure: MEMORY holds dmem_req until dmem_ready; MEM_TIMEOUT consecutive waits fault.
// Optional single-step/halt support is compiled in with `define MPS_SEQ_STEP_EN.
module mps_sequencer #(
  parameter int MEM_TIMEOUT   = 16,
  parameter int RETIRED_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     nreset,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic                     reg_d_enable,
  input  logic                     dmem_ready,
`ifdef MPS_SEQ_STEP_EN
  input  logic                     halt_req,
  input  logic                     step,
`endif
  output logic [2:0]               state,
  output logic                     ir_load,
  output logic                     alu_latch,
  output logic                     dmem_req,
  output logic                     dmem_wenable,
  output logic                     rf_write,
  output logic                     pc_enable,
  output logic                     retired,
  output logic [RETIRED_WIDTH-1:0] retired_count,
  output logic                     halted,
  output logic                     fault
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALTED    = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  // Wait counter only needs to reach MEM_TIMEOUT-1; the timeout fires when a
  // further not-ready cycle would make it MEM_TIMEOUT.
  localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam bit TO_EN = (MEM_TIMEOUT != 0);
  localparam logic [WW-1:0] TO_LAST = WW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_t                   r_state;
  logic                     r_f_rd;
  logic                     r_f_wr;
  logic                     r_f_rdst;
  logic [WW-1:0]            r_wait;
  logic [RETIRED_WIDTH-1:0] r_retired_count;

  // Stage sequencing, decode flag capture, memory wait tracking and retire counting.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_state         <= S_IDLE;
      r_f_rd          <= 1'b0;
      r_f_wr          <= 1'b0;
      r_f_rdst        <= 1'b0;
      r_wait          <= '0;
      r_retired_count <= '0;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= S_FETCH;
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_f_rd   <= mem_read;
          r_f_wr   <= mem_write;
          r_f_rdst <= reg_d_enable;
          // A simultaneous load and store is not a legal instruction.
          if (mem_read && mem_write) r_state <= S_FAULT;
          else                       r_state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          r_wait <= '0;
          if (r_f_rd || r_f_wr) r_state <= S_MEMORY;
          else                  r_state <= S_WRITEBACK;
        end
        S_MEMORY: begin
          // Ready on the final allowed cycle still completes normally.
          if (dmem_ready)                        r_state <= S_WRITEBACK;
          else if (TO_EN && (r_wait == TO_LAST)) r_state <= S_FAULT;
          else                                   r_wait  <= r_wait + 1'b1;
        end
        S_WRITEBACK: begin
          r_retired_count <= r_retired_count + 1'b1;
`ifdef MPS_SEQ_STEP_EN
          if (halt_req) r_state <= S_HALTED;
          else          r_state <= S_FETCH;
`else
          r_state <= S_FETCH;
`endif
        end
        S_HALTED: begin
`ifdef MPS_SEQ_STEP_EN
          if (step) r_state <= S_FETCH;
`else
          // HALTED has no way out without step support; treat entry as corruption.
          r_state <= S_FAULT;
`endif
        end
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_FAULT;
      endcase
    end
  end

  // Strobes are pure decodes of the registered state and captured flags.
  assign state         = r_state;
  assign ir_load       = (r_state == S_FETCH);
  assign alu_latch     = (r_state == S_EXECUTE);
  assign dmem_req      = (r_state == S_MEMORY);
  assign dmem_wenable  = (r_state == S_MEMORY) && r_f_wr;
  assign rf_write      = (r_state == S_WRITEBACK) && r_f_rdst;
  assign pc_enable     = (r_state == S_WRITEBACK);
  assign retired       = (r_state == S_WRITEBACK);
  assign retired_count = r_retired_count;
  assign fault         = (r_state == S_FAULT);
`ifdef MPS_SEQ_STEP_EN
  assign halted        = (r_state == S_HALTED);
`else
  assign halted        = 1'b0;
`endif

endmodule

// File: tb/tb_mps_sequencer.sv
// Self-checking bench for mps_sequencer: cycle-by-cycle comparison against an
// instruction-level model that expands each instruction into its expected stage trace.
module tb_mps_sequencer;

  localparam int TO = 4;
  localparam int RW = 4;

  logic          clock = 1'b0;
  logic          nreset = 1'b0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic          reg_d_enable = 1'b0;
  logic          dmem_ready = 1'b0;
`ifdef MPS_SEQ_STEP_EN
  logic          halt_req = 1'b0;
  logic          step = 1'b0;
`endif
  logic [2:0]    state;
  logic          ir_load, alu_latch, dmem_req, dmem_wenable, rf_write;
  logic          pc_enable, retired, halted, fault;
  logic [RW-1:0] retired_count;

  int n_checks = 0;
  int n_errors = 0;
  int m_cnt = 0;        // model retired count
  bit m_faulted = 0;    // model says the DUT sits in FAULT

  always #5 clock = ~clock;

  mps_sequencer #(.MEM_TIMEOUT(TO), .RETIRED_WIDTH(RW)) dut (
    .clock(clock), .nreset(nreset),
    .mem_read(mem_read), .mem_write(mem_write), .reg_d_enable(reg_d_enable),
    .dmem_ready(dmem_ready),
`ifdef MPS_SEQ_STEP_EN
    .halt_req(halt_req), .step(step),
`endif
    .state(state), .ir_load(ir_load), .alu_latch(alu_latch), .dmem_req(dmem_req),
    .dmem_wenable(dmem_wenable), .rf_write(rf_write), .pc_enable(pc_enable),
    .retired(retired), .retired_count(retired_count), .halted(halted), .fault(fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected output vector: {count[15:0], 4'b0, state, ir, alu, req, wen, rfw, pce, ret, halted, fault}
  function automatic logic [31:0] pk(input int st, input bit ir, input bit alu, input bit req,
                                     input bit wen, input bit rfw, input bit pce, input bit ret);
    logic [31:0] v;
    v = '0;
    v[31:16] = 16'(m_cnt);
    v[11:9]  = 3'(st);
    v[8] = ir;  v[7] = alu; v[6] = req; v[5] = wen;
    v[4] = rfw; v[3] = pce; v[2] = ret;
    v[1] = (st == 6);
    v[0] = (st == 7);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] exp);
    logic [31:0] obs;
    obs = '0;
    obs[31:16] = 16'(retired_count);
    obs[11:9]  = state;
    obs[8] = ir_load;  obs[7] = alu_latch; obs[6] = dmem_req; obs[5] = dmem_wenable;
    obs[4] = rf_write; obs[3] = pc_enable; obs[2] = retired;
    obs[1] = halted;   obs[0] = fault;
    check(tag, obs, exp);
  endtask

  // Check the current cycle, present dmem_ready for the coming edge, advance one cycle.
  task automatic do_cycle(input string tag, input logic [31:0] exp, input bit rdy);
    chk(tag, exp);
    dmem_ready = rdy;
    @(negedge clock);
  endtask

  task automatic fault_hold();
    for (int i = 0; i < 3; i++) begin
      mem_read  = 1'($urandom);
      mem_write = 1'($urandom);
      do_cycle("fault", pk(7, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
    end
    m_faulted = 1;
  endtask

  // One reset edge, then the IDLE cycle; returns positioned on the first FETCH.
  task automatic reset_dut();
    nreset = 1'b0;
    dmem_ready = 1'($urandom);
    @(negedge clock);
    nreset = 1'b1;
    m_cnt = 0;
    m_faulted = 0;
    do_cycle("idle", pk(0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
  endtask

  // One instruction starting in FETCH. nw = not-ready cycles before dmem_ready.
  task automatic run_instr(input bit rd, input bit wr, input bit rdst, input int nw);
    int mcyc;
    mem_read = rd; mem_write = wr; reg_d_enable = rdst;
    do_cycle("fetch", pk(1, 1, 0, 0, 0, 0, 0, 0), 1'($urandom));
    do_cycle("decode", pk(2, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
    // Control may change once DECODE has captured it.
    mem_read = 1'($urandom); mem_write = 1'($urandom); reg_d_enable = 1'($urandom);
    if (rd && wr) begin
      fault_hold();
      return;
    end
    do_cycle("execute", pk(3, 0, 1, 0, 0, 0, 0, 0), 1'($urandom));
    if (rd || wr) begin
      mcyc = (nw < TO) ? nw + 1 : TO;
      for (int k = 0; k < mcyc; k++)
        do_cycle("memory", pk(4, 0, 0, 1, wr, 0, 0, 0), k >= nw);
      if (nw >= TO) begin
        fault_hold();
        return;
      end
    end
    do_cycle("writeback", pk(5, 0, 0, 0, 0, rdst, 1, 1), 1'($urandom));
    m_cnt = (m_cnt + 1) % (1 << RW);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("reset_state", pk(0, 0, 0, 0, 0, 0, 0, 0));
    reset_dut();

    // ALU-only stream of 10
    for (int i = 0; i < 10; i++) run_instr(0, 0, 1, 0);
    check("count_after_10", 32'(retired_count), 32'd10);

    // Store with 3 wait cycles, no rd write
    run_instr(0, 1, 0, 3);
    // Load ready on the 4th MEMORY cycle retires
    run_instr(1, 0, 1, TO - 1);
    check("count_after_mem", 32'(retired_count), 32'd12);
    // Load that never becomes ready times out; count frozen
    run_instr(1, 0, 1, 10);
    check("count_frozen", 32'(retired_count), 32'd12);
    reset_dut();

    // Illegal load+store, then recover by reset
    run_instr(1, 1, 1, 0);
    reset_dut();

    // Reset in the middle of MEMORY drops dmem_req next cycle
    run_instr(0, 0, 0, 0);
    mem_read = 1; mem_write = 0; reg_d_enable = 1;
    do_cycle("fetch", pk(1, 1, 0, 0, 0, 0, 0, 0), 0);
    do_cycle("decode", pk(2, 0, 0, 0, 0, 0, 0, 0), 0);
    do_cycle("execute", pk(3, 0, 1, 0, 0, 0, 0, 0), 0);
    chk("memory_pre_rst", pk(4, 0, 0, 1, 0, 0, 0, 0));
    nreset = 1'b0;
    dmem_ready = 1'b0;
    @(negedge clock);
    nreset = 1'b1;
    m_cnt = 0;
    do_cycle("rst_mid_mem", pk(0, 0, 0, 0, 0, 0, 0, 0), 0);

    // Counter wrap: 17 retires on a 4-bit counter
    for (int i = 0; i < 17; i++) run_instr(0, 0, 1'($urandom), 0);
    check("wrap_count", 32'(retired_count), 32'd1);

`ifdef MPS_SEQ_STEP_EN
    halt_req = 1'b1;
    run_instr(0, 0, 1, 0);
    for (int s = 0; s < 3; s++) begin
      do_cycle("halted", pk(6, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
      do_cycle("halted", pk(6, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
      step = 1'b1;
      do_cycle("halted_step", pk(6, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
      step = 1'b0;
      run_instr(1'($urandom), 1'b0, 1'($urandom), $urandom_range(0, 2));
    end
    halt_req = 1'b0;
    step = 1'b1;
    do_cycle("halted_go", pk(6, 0, 0, 0, 0, 0, 0, 0), 0);
    step = 1'b0;
    run_instr(0, 0, 1, 0);
    run_instr(0, 1, 0, 1);
`endif

    // Randomized instruction mix, recovering from faults with a reset
    for (int i = 0; i < 200; i++) begin
      int sel;
      bit rd, wr;
      sel = $urandom_range(0, 9);
      rd = (sel == 0) || (sel >= 7);
      wr = (sel == 0) || (sel == 5) || (sel == 6);
      run_instr(rd, wr, 1'($urandom), $urandom_range(0, 5));
      if (m_faulted) reset_dut();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
